// File: rtl/wishbone_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wishbone_pkg
// Brief   : Shared bus widths, arbiter state encoding and timeout default.
// Revision: 1.0 - initial release
// ============================================================================
package wishbone_pkg;

    localparam int WB_ADDR_W       = 32;
    localparam int WB_DATA_W       = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_t;

    // One-hot owner view of a state; ERR and IDLE have no owner.
    function automatic logic [1:0] grant_of(input arb_state_t st);
        logic [1:0] g;
        g = 2'b00;
        if (st == ST_OWN0) g = 2'b01;
        if (st == ST_OWN1) g = 2'b10;
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module  : wb_timeout_counter
// Brief   : Counts consecutive unacknowledged strobe cycles of the bus owner.
// Revision: 1.0 - initial release
// ============================================================================
module wb_timeout_counter
    import wishbone_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam int              CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != C_LIMIT)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Flags the wait cycle that brings the count to TIMEOUT so the FSM leaves
    // on that very edge; an ack in this cycle drops i_enable and wins.
    assign o_expired = i_enable & (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/wishbone_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wishbone_arbiter
// Brief   : Two-master round-robin Wishbone arbiter with per-owner timeout.
// Revision: 1.0 - initial release
// ============================================================================
module wishbone_arbiter
    import wishbone_pkg::*;
#(
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_ack_i,

    output logic [1:0]        grant_o
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last_owner;
    logic       w_own0;
    logic       w_own1;
    logic       w_in_err;
    logic       w_expired;
    logic       w_cnt_en;
    logic       w_cnt_clr;

    assign w_own0   = (r_state == ST_OWN0);
    assign w_own1   = (r_state == ST_OWN1);
    assign w_in_err = (r_state == ST_ERR);

    assign w_cnt_en  = (w_own0 | w_own1) & s_stb_o & ~s_ack_i;
    assign w_cnt_clr = ~w_cnt_en | (w_next_state != r_state);

    wb_timeout_counter #(
        .TIMEOUT   (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_enable  (w_cnt_en),
        .i_clear   (w_cnt_clr),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next_state = r_last_owner ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    w_next_state = ST_OWN0;
                end else if (m1_cyc_i) begin
                    w_next_state = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    w_next_state = ST_IDLE;
                end else if (w_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    w_next_state = ST_IDLE;
                end else if (w_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_ERR:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // last_owner is updated when ownership ends (to IDLE or ERR), so in ERR
    // it already names the master that timed out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
        end else begin
            r_state <= w_next_state;
            if (w_own0 && (w_next_state != ST_OWN0)) begin
                r_last_owner <= 1'b0;
            end else if (w_own1 && (w_next_state != ST_OWN1)) begin
                r_last_owner <= 1'b1;
            end
        end
    end

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m0_ack_o  = 1'b0;
        m0_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_data_o = '0;
        if (w_own0) begin
            s_cyc_o   = m0_cyc_i;
            s_stb_o   = m0_stb_i;
            s_we_o    = m0_we_i;
            s_addr_o  = m0_addr_i;
            s_data_o  = m0_data_i;
            m0_ack_o  = s_ack_i;
            m0_data_o = s_data_i;
        end else if (w_own1) begin
            s_cyc_o   = m1_cyc_i;
            s_stb_o   = m1_stb_i;
            s_we_o    = m1_we_i;
            s_addr_o  = m1_addr_i;
            s_data_o  = m1_data_i;
            m1_ack_o  = s_ack_i;
            m1_data_o = s_data_i;
        end
    end

    assign m0_err_o = w_in_err & ~r_last_owner;
    assign m1_err_o = w_in_err &  r_last_owner;
    assign grant_o  = grant_of(r_state);

endmodule
`default_nettype wire

// File: tb/tb_wishbone_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wishbone_arbiter
// Brief   : Vector table, directed corner sequences and random run vs. model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wishbone_arbiter;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_ack_i;
    logic [1:0]  grant_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner index (-1 none), master in error cycle, history.
    int md_owner, md_err, md_last, md_waits;

    typedef struct packed {
        logic       m0c, m0s, m1c, m1s, ack;
        logic [1:0] grant;
        logic       sstb, a0, a1;
    } vec_t;

    vec_t tbl [14];

    wishbone_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_data_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_data_i = '0;
        s_ack_i  = 0; s_data_i = '0;
    endtask

    task automatic model_reset();
        md_owner = -1; md_err = -1; md_last = 1; md_waits = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic model_check();
        logic [1:0]  eg;
        logic        ec, es, ew, ea0, ee0, ea1, ee1;
        logic [31:0] ead, eda, ed0, ed1;
        eg = 2'b00; ec = 0; es = 0; ew = 0; ea0 = 0; ee0 = 0; ea1 = 0; ee1 = 0;
        ead = '0; eda = '0; ed0 = '0; ed1 = '0;
        if (md_owner == 0) begin
            eg = 2'b01; ec = m0_cyc_i; es = m0_stb_i; ew = m0_we_i;
            ead = m0_addr_i; eda = m0_data_i; ea0 = s_ack_i; ed0 = s_data_i;
        end else if (md_owner == 1) begin
            eg = 2'b10; ec = m1_cyc_i; es = m1_stb_i; ew = m1_we_i;
            ead = m1_addr_i; eda = m1_data_i; ea1 = s_ack_i; ed1 = s_data_i;
        end
        if (md_err == 0) ee0 = 1;
        if (md_err == 1) ee1 = 1;
        chk("rnd_ctrl", 32'({grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}),
            32'({eg, ec, es, ew, ea0, ee0, ea1, ee1}));
        chk("rnd_s_addr", s_addr_o, ead);
        chk("rnd_s_data", s_data_o, eda);
        chk("rnd_m0_data", m0_data_o, ed0);
        chk("rnd_m1_data", m1_data_o, ed1);
    endtask

    // Advances the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        logic oc, os;
        if (md_err >= 0) begin
            md_last = md_err; md_err = -1; md_waits = 0;
        end else if (md_owner >= 0) begin
            oc = (md_owner == 0) ? m0_cyc_i : m1_cyc_i;
            os = (md_owner == 0) ? m0_stb_i : m1_stb_i;
            if (!oc) begin
                md_last = md_owner; md_owner = -1; md_waits = 0;
            end else if (os && !s_ack_i) begin
                if (md_waits + 1 >= TMO) begin
                    md_err = md_owner; md_owner = -1; md_waits = 0;
                end else begin
                    md_waits++;
                end
            end else begin
                md_waits = 0;
            end
        end else if (m0_cyc_i && m1_cyc_i) begin
            md_owner = (md_last == 0) ? 1 : 0;
        end else if (m0_cyc_i) begin
            md_owner = 0;
        end else if (m1_cyc_i) begin
            md_owner = 1;
        end
    endtask

    initial begin
        bit quiet;
        // m0c m0s m1c m1s ack | grant | s_stb m0_ack m1_ack
        tbl[0]  = 10'b00001_00_000;
        tbl[1]  = 10'b11000_00_000;
        tbl[2]  = 10'b11000_01_100;
        tbl[3]  = 10'b11000_01_100;
        tbl[4]  = 10'b11000_01_100;
        tbl[5]  = 10'b11001_01_110;
        tbl[6]  = 10'b00000_01_000;
        tbl[7]  = 10'b11110_00_000;
        tbl[8]  = 10'b11111_10_101;
        tbl[9]  = 10'b11000_10_000;
        tbl[10] = 10'b11000_00_000;
        tbl[11] = 10'b11001_01_110;
        tbl[12] = 10'b00000_01_000;
        tbl[13] = 10'b00001_00_000;

        rst_n = 1'b0;
        clear_inputs();

        // Vector table: single-master read, tie-break, release and idle gap.
        do_reset();
        s_data_i = 32'hDEADBEEF; m0_addr_i = 32'h10; m1_addr_i = 32'h20; m1_we_i = 1;
        for (int i = 0; i < 14; i++) begin
            m0_cyc_i = tbl[i].m0c; m0_stb_i = tbl[i].m0s;
            m1_cyc_i = tbl[i].m1c; m1_stb_i = tbl[i].m1s;
            s_ack_i  = tbl[i].ack;
            #1;
            chk($sformatf("tbl%0d_ctrl", i),
                32'({grant_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}),
                32'({tbl[i].grant, tbl[i].sstb, tbl[i].a0, tbl[i].a1, 2'b00}));
            chk($sformatf("tbl%0d_m0_data", i), m0_data_o, tbl[i].grant[0] ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("tbl%0d_m1_data", i), m1_data_o, tbl[i].grant[1] ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("tbl%0d_s_addr", i), s_addr_o,
                tbl[i].grant[0] ? 32'h10 : (tbl[i].grant[1] ? 32'h20 : 32'h0));
            tick();
        end

        // Simultaneous first requests after reset: m0 first, m1 after an idle cycle.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        #1; chk("tie_idle_grant", 32'(grant_o), 32'h0);
        tick(); chk("tie_first_grant", 32'(grant_o), 32'h1);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick(); chk("tie_gap_grant", 32'(grant_o), 32'h0);
        tick(); chk("tie_second_grant", 32'(grant_o), 32'h2);

        // m1 block write of four beats is not split by an m0 request.
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h100; m1_data_i = 32'hA000;
        m0_addr_i = 32'h10;
        #1; chk("blk_idle_grant", 32'(grant_o), 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
            m1_addr_i = 32'h100 + 32'(k); m1_data_i = 32'hA000 + 32'(k);
            #1;
            chk($sformatf("blk%0d_ctrl", k), 32'({grant_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m0_ack_o}),
                32'({2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}));
            chk($sformatf("blk%0d_addr", k), s_addr_o, 32'h100 + 32'(k));
            chk($sformatf("blk%0d_data", k), s_data_o, 32'hA000 + 32'(k));
            tick();
        end
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        #1; chk("blk_release_grant", 32'(grant_o), 32'h2);
        tick(); chk("blk_gap_grant", 32'(grant_o), 32'h0);
        tick(); chk("blk_m0_grant", 32'(grant_o), 32'h1);
        chk("blk_m0_addr", s_addr_o, 32'h10);

        // Slave never acks: eight strobe cycles, then one error cycle, then idle.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h44;
        tick();
        for (int w = 0; w < TMO; w++) begin
            chk($sformatf("to_wait%0d", w), 32'({grant_o, s_stb_o, m0_err_o}), 32'({2'b01, 1'b1, 1'b0}));
            tick();
        end
        chk("to_err_cycle", 32'({grant_o, s_cyc_o, s_stb_o, m0_ack_o, m0_err_o, m1_err_o}),
            32'({2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        tick();
        chk("to_back_idle", 32'({grant_o, s_stb_o, m0_err_o}), 32'h0);
        tick();
        chk("to_regrant", 32'(grant_o), 32'h1);

        // Ack on the last permitted strobe cycle wins over the timeout.
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        for (int w = 0; w < TMO - 1; w++) tick();
        s_ack_i = 1;
        #1; chk("ack_edge_cycle", 32'({grant_o, m0_ack_o, m0_err_o}), 32'({2'b01, 1'b1, 1'b0}));
        tick(); s_ack_i = 0;
        #1; chk("ack_edge_after", 32'({grant_o, m0_err_o}), 32'({2'b01, 1'b0}));

        // Asynchronous reset during an m1 strobe; pending m0 granted right after.
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h88; m1_data_i = 32'h55;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1; s_data_i = 32'h1234;
        #1; chk("rst_pre_ctrl", 32'({grant_o, s_stb_o, m1_ack_o}), 32'({2'b10, 1'b1, 1'b1}));
        #2; rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", 32'({grant_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'h0);
        chk("rst_async_bus", s_addr_o | s_data_o, 32'h0);
        chk("rst_async_mdata", m0_data_o | m1_data_o, 32'h0);
        m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_first_grant", 32'(grant_o), 32'h1);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            quiet = ((c / 100) % 2) == 1;
            if (m0_cyc_i) begin
                if ($urandom_range(0, 9) == 0) m0_cyc_i = 0;
            end else if ($urandom_range(0, 3) == 0) m0_cyc_i = 1;
            if (m1_cyc_i) begin
                if ($urandom_range(0, 9) == 0) m1_cyc_i = 0;
            end else if ($urandom_range(0, 3) == 0) m1_cyc_i = 1;
            m0_stb_i  = m0_cyc_i & (m0_stb_i | 1'($urandom_range(0, 1)));
            m1_stb_i  = m1_cyc_i & (m1_stb_i | 1'($urandom_range(0, 1)));
            m0_we_i   = 1'($urandom_range(0, 1));
            m1_we_i   = 1'($urandom_range(0, 1));
            m0_addr_i = $urandom(); m0_data_i = $urandom();
            m1_addr_i = $urandom(); m1_data_i = $urandom();
            s_data_i  = $urandom();
            s_ack_i   = quiet ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
            #1;
            model_check();
            model_edge();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, master/slave address width.
REQ-002 SHALL have parameter DATA_W, default 32, data bus width.
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles an owner strobe may wait for ack before error.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports mN_cyc_i / mN_stb_i / mN_we_i (N=0,1)  input  1 each  master N bus cycle, strobe, write enable.
REQ-007 SHALL have ports mN_addr_i  input  ADDR_W, and mN_data_i  input  DATA_W  master N address and write data.
REQ-008 SHALL have ports mN_data_o  output  DATA_W  read data returned to master N.
REQ-009 SHALL have ports mN_ack_o and mN_err_o  output  1 each  master N acknowledge and timeout error.
REQ-010 SHALL have ports s_cyc_o / s_stb_o / s_we_o  output  1 each, s_addr_o  output  ADDR_W, s_data_o  output  DATA_W  to the shared slave (DM / LED slave).
REQ-011 SHALL have ports s_data_i  input  DATA_W and s_ack_i  input  1  from the slave.
REQ-012 SHALL have port grant_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 2'b00 when idle.

Function
REQ-013 SHALL implement FSM states IDLE, OWN0, OWN1, ERR.
REQ-014 IDLE: any mN_cyc_i high -> OWNN on the next edge; no slave signal driven active while in IDLE.
REQ-015 Simultaneous requests in IDLE SHALL be granted to the master not served last (round-robin); last_owner resets to 1, so m0 wins the first tie.
REQ-016 OWNN: s_cyc_o/s_stb_o/s_we_o/s_addr_o/s_data_o SHALL combinationally follow master N; the other master's inputs are ignored.
REQ-017 OWNN: mN_ack_o = s_ack_i and mN_data_o = s_data_i combinationally (zero added latency after grant); the non-owner sees ack = 0, err = 0, data = 0.
REQ-018 Ownership SHALL be held across multiple strobes while mN_cyc_i stays high (block transfers are never split).
REQ-019 OWNN -> IDLE on the edge after mN_cyc_i falls; last_owner <= N; re-arbitration happens from IDLE (minimum one idle cycle between owners).
REQ-020 A wait counter SHALL count cycles with s_stb_o high and s_ack_i low, clear on ack, clear when stb falls, and clear on state change.
REQ-021 When the counter reaches TIMEOUT (counter width = clog2(TIMEOUT+1)), it SHALL go to ERR: s_cyc_o/s_stb_o forced low, mN_err_o high for exactly one cycle, then -> IDLE with last_owner <= N.
REQ-022 An ack arriving in the same cycle the counter hits TIMEOUT SHALL win: it is passed as ack, and no error occurs.
REQ-023 An ack from the slave while in IDLE or ERR SHALL be dropped (not forwarded).
REQ-024 mN_ack_o and mN_err_o SHALL never be high simultaneously.

Reset
REQ-025 rst_n low SHALL immediately force the state to IDLE, last_owner to 1, the counter to 0, grant_o to 2'b00, and all s_* and mN_ack_o/mN_err_o/mN_data_o to 0, including mid-transfer.
REQ-026 After rst_n rises, the first arbitration SHALL occur on the first clock edge with a request.

Structure
REQ-027 The state encoding and the DEFAULT_TIMEOUT constant SHALL live in a shared package wishbone_pkg, together with the bus widths used by wishbone_master and the slaves.
REQ-028 The timeout counter SHALL be one sub-module, wb_timeout_counter (inputs: enable, clear; output: expired); everything else is flat.

Verification
REQ-029 Only m0 cyc/stb read addr 0x10, slave acks after 3 cycles with 0xDEADBEEF -> m0_ack_o 1 cycle, m0_data_o = 0xDEADBEEF, grant_o = 01, m1 outputs 0.
REQ-030 m0 and m1 assert cyc on the same edge after reset -> m0 granted first; after m0 drops cyc and one idle cycle, grant_o = 10.
REQ-031 m1 holds cyc over 4 write strobes while m0 requests -> all 4 writes reach the slave uninterrupted; m0 is granted only after m1 releases.
REQ-032 TIMEOUT = 8, slave never acks m0 -> s_stb_o falls and m0_err_o pulses 1 cycle after 8 wait cycles, then the FSM returns to IDLE.
REQ-033 TIMEOUT = 8, ack on wait cycle 8 -> m0_ack_o asserted and m0_err_o stays 0.
REQ-034 rst_n pulled low during an m1 strobe -> all outputs are 0 within the same cycle (asynchronously); after release, a pending m0 request is granted on the first edge.
